// File: rtl/demux_1to2_buf.sv
// rtl/demux_1to2_buf.sv - 1:2 stream demultiplexer with a per-channel FIFO
//
// Purpose: receive side of the 2:1 channel mux. Each incoming word is routed
// to channel A (in_sel=0) or channel B (in_sel=1) and queued in that channel's
// own DEPTH-entry FIFO, so a stalled consumer on one channel cannot corrupt or
// reorder the other.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_data/in_sel/in_valid      input word, channel select, qualifier
//   in_ready                     word is accepted this cycle
//   a_data/a_valid/a_ready       channel A head word and handshake
//   a_level                      channel A occupancy, 0..DEPTH
//   b_data/b_valid/b_ready       channel B head word and handshake
//   b_level                      channel B occupancy, 0..DEPTH

// Per-channel FIFO. push must only be asserted when there is room; it is
// gated again here so an overfull push can never corrupt the pointers.
module demux_1to2_buf_fifo #(
  parameter int N     = 4,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [N-1:0]  push_data,
  input  logic          ready,
  output logic [N-1:0]  data,
  output logic          valid,
  output logic [LW-1:0] level,
  output logic          full
);
  localparam int PW = $clog2(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign valid   = (level != '0);
  assign data    = mem[rd_ptr];
  assign do_push = push && !full;
  // ready while empty is ignored, so the level cannot underflow
  assign do_pop  = valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        // DEPTH is a power of two, so natural pointer overflow is the wrap
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module demux_1to2_buf #(
  parameter  int N     = 4,
  parameter  int DEPTH = 2,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  a_data,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [LW-1:0] a_level,
  output logic [N-1:0]  b_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [LW-1:0] b_level
);
  logic a_full;
  logic b_full;
  logic accept;

  // Depends only on the selected channel's occupancy, never on the consumer
  // ready: a full channel does not accept a word even if it pops this cycle.
  assign in_ready = in_sel ? !b_full : !a_full;
  assign accept   = in_valid && in_ready;

  demux_1to2_buf_fifo #(.N(N), .DEPTH(DEPTH), .LW(LW)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept && !in_sel),
    .push_data (in_data),
    .ready     (a_ready),
    .data      (a_data),
    .valid     (a_valid),
    .level     (a_level),
    .full      (a_full)
  );

  demux_1to2_buf_fifo #(.N(N), .DEPTH(DEPTH), .LW(LW)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept && in_sel),
    .push_data (in_data),
    .ready     (b_ready),
    .data      (b_data),
    .valid     (b_valid),
    .level     (b_level),
    .full      (b_full)
  );
endmodule
